taillight_input_cond: RTL and testbench
=======================================

# taillight_input_cond

Front-end stage for the sequential taillight controller. It takes the raw asynchronous driver switches (left, right, brake, hazard, running light) and produces synchronized, debounced levels. From the single system clock it also generates the slow sequence-step clock and the faster dimmer clock that the controller and dimmer consume. Every output is registered and clean, with no glitches.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages per switch input; minimum 2.
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles a new synced value must persist to be accepted; minimum 1.
- `STEP_DIV`, default 6250000: `clk` cycles per `step_clk` half-period and per `step_tick`; minimum 2.
- `DIM_DIV`, default 25000: `clk` cycles per `dim_clk` half-period and per `dim_tick`; minimum 2.

Ports:
- `clk` in 1: system clock; all logic runs on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `sw_left`, `sw_right`, `sw_brake`, `sw_hazard`, `sw_run` in 1 each: raw switch inputs, asynchronous to `clk`.
- `left`, `right`, `brake`, `hazard`, `runlight` out 1 each: debounced levels.
- `step_clk` out 1: 50 % square wave with period 2·`STEP_DIV`; drives the controller clock.
- `dim_clk` out 1: 50 % square wave with period 2·`DIM_DIV`; drives the dimmer clock.
- `step_tick`, `dim_tick` out 1: one-cycle pulse coincident with every `step_clk` / `dim_clk` toggle.

## Operation
- **Reset state.**
  - While `rst`=0, all registers clear immediately: sync chains, stable values, debounce counters and both divider counters.
  - All outputs read 0 during reset.
- **Synchronizer.** Each input passes through its own `SYNC_STAGES` flip-flop chain.
- **Debounce, per channel independently.**
  - The channel holds a `stable` register and a counter sized `$clog2(DEBOUNCE_CYCLES+1)`.
  - If the synced value equals `stable`, the counter clears to 0.
  - Otherwise the counter increments. On the edge where it would reach `DEBOUNCE_CYCLES`, `stable` takes the synced value and the counter clears.
  - A synced pulse shorter than `DEBOUNCE_CYCLES` cycles is discarded.
  - A pulse that bounces back before acceptance restarts the count from 0.
- **Dividers (step and dim identical; N = `STEP_DIV` or `DIM_DIV`).**
  - The counter runs 0 to N−1 and is `$clog2(N)` bits wide.
  - On the edge where the counter equals N−1: the counter wraps to 0, the tick register is set to 1 for one cycle, and the clock output toggles.
  - On all other edges: the counter increments and the tick is 0.
- The dividers are free-running and independent of the switch values, except where **Configuration** states otherwise.

## Timing
- **Debounce latency.** A raw change that is held steady appears on the debounced output exactly `SYNC_STAGES`+`DEBOUNCE_CYCLES` rising edges after the first edge that samples it. Metastability can add at most ±1 cycle of uncertainty.
- **First events after reset release.**
  - `step_tick` first pulses in the cycle after the `STEP_DIV`-th rising edge.
  - `step_clk` first rises on that same edge. Subsequent toggles follow every `STEP_DIV` edges.
  - The same rule applies to the dim divider with `DIM_DIV`.
- **Output registration.** `step_clk` and `dim_clk` come directly from flops, with no combinational path. Downstream logic may use them as clocks.
- **Simultaneous events.**
  - Debounce acceptance on several channels in the same cycle updates them all in that cycle.
  - A tick and a debounced change in the same cycle are independent and both take effect.
- **Reset mid-operation.** Asserting reset mid-operation drops `step_clk` and `dim_clk` low asynchronously. Timing then restarts from the rules above.

## Configuration
- Macro: `TAILLIGHT_STEP_RESYNC_EN`.
- **When defined:**
  - Any change of the debounced `{left, right, hazard}` in cycle t forces the step divider counter to 0 and `step_clk` to 0 on edge t+1. No `step_tick` occurs on that edge.
  - Resync wins over a coincident wrap.
  - As a result, a new turn or hazard sequence always begins with a full `STEP_DIV` cycles before its first `step_clk` rise.
  - Brake and run changes do not resync.
  - The dim divider is unaffected.
- **When not defined:** the step divider is free-running, and sequence phase is arbitrary relative to switch activation.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `STEP_DIV`=8, `DIM_DIV`=3.
1. **Reset.** Release reset with all switches at 0 → all outputs 0. `step_clk` first rises on edge 8 and `dim_clk` on edge 3. `step_tick` pulses every 8 cycles and `dim_tick` every 3 cycles.
2. **Clean debounce.** Raise `sw_left` and hold → `left`=1 exactly 6 edges after the first sampling edge. Drop `sw_left` → `left`=0 6 edges later.
3. **Glitch rejection.** Pulse `sw_brake` high for 3 cycles, then 0 → `brake` stays 0. Bounce 1,1,0,1,1,1,1 → `brake` rises only after the final 4-cycle run.
4. **Mid-operation reset.** Assert `rst`=0 asynchronously while `step_clk`=1 and `hazard`=1 → both outputs drop before the next edge. After release, the first `step_clk` rise is at edge 8.
5. **Resync (macro defined).** Debounced `right` rises while the step counter is 5 → counter and `step_clk` are 0 on the next edge, and the next `step_tick` comes 8 edges later. With the counter at 7 (coincident wrap) → no tick on that edge.
6. **Free-running (macro undefined).** Same stimulus as scenario 5 → `step_tick` timing is unchanged from the free-running 8-cycle cadence.

Source files
------------

// File: rtl/taillight_input_cond.sv
// Taillight front end: per-switch synchronizer + debounce lanes and the step/dim clock dividers.
// Optional macro TAILLIGHT_STEP_RESYNC_EN restarts the step divider on any turn/hazard change.

module taillight_db_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sw};
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module taillight_div #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic resync,
  output logic div_clk,
  output logic tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Resync has priority over the wrap so a restarted phase never emits a stray tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (resync) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      div_clk <= ~div_clk;
      tick    <= 1'b1;
    end else begin
      cnt  <= cnt + W'(1);
      tick <= 1'b0;
    end
  end
endmodule

module taillight_input_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_DIV        = 6250000,
  parameter int DIM_DIV         = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_left,
  input  logic sw_right,
  input  logic sw_brake,
  input  logic sw_hazard,
  input  logic sw_run,
  output logic left,
  output logic right,
  output logic brake,
  output logic hazard,
  output logic runlight,
  output logic step_clk,
  output logic dim_clk,
  output logic step_tick,
  output logic dim_tick
);
  localparam int NUM_CH = 5;

  logic [NUM_CH-1:0] sw_vec;
  logic [NUM_CH-1:0] db_vec;
  logic              step_resync;

  assign sw_vec = {sw_run, sw_hazard, sw_brake, sw_right, sw_left};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    taillight_db_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .sw    (sw_vec[i]),
      .stable(db_vec[i])
    );
  end

  assign left     = db_vec[0];
  assign right    = db_vec[1];
  assign brake    = db_vec[2];
  assign hazard   = db_vec[3];
  assign runlight = db_vec[4];

`ifdef TAILLIGHT_STEP_RESYNC_EN
  logic [2:0] turn_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) turn_q <= '0;
    else      turn_q <= {left, right, hazard};
  end

  assign step_resync = (turn_q != {left, right, hazard});
`else
  assign step_resync = 1'b0;
`endif

  taillight_div #(.DIV(STEP_DIV)) u_step_div (
    .clk    (clk),
    .rst    (rst),
    .resync (step_resync),
    .div_clk(step_clk),
    .tick   (step_tick)
  );

  taillight_div #(.DIV(DIM_DIV)) u_dim_div (
    .clk    (clk),
    .rst    (rst),
    .resync (1'b0),
    .div_clk(dim_clk),
    .tick   (dim_tick)
  );
endmodule

// File: tb/tb_taillight_input_cond.sv
// Directed bench for taillight_input_cond (SYNC=2, DEBOUNCE=4, STEP_DIV=8, DIM_DIV=3).
module tb_taillight_input_cond;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sw_left = 0, sw_right = 0, sw_brake = 0, sw_hazard = 0, sw_run = 0;
  logic left, right, brake, hazard, runlight;
  logic step_clk, dim_clk, step_tick, dim_tick;

  int vecs = 0;
  int errs = 0;

  taillight_input_cond #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .STEP_DIV(8), .DIM_DIV(3)
  ) dut (
    .clk(clk), .rst(rst),
    .sw_left(sw_left), .sw_right(sw_right), .sw_brake(sw_brake),
    .sw_hazard(sw_hazard), .sw_run(sw_run),
    .left(left), .right(right), .brake(brake), .hazard(hazard), .runlight(runlight),
    .step_clk(step_clk), .dim_clk(dim_clk), .step_tick(step_tick), .dim_tick(dim_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench on a falling edge with reset released; the next rising edge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    bit sc_e, st_e, dc_e, dt_e;
    repeat (3) @(negedge clk);
    outs = {left, right, brake, hazard, runlight, step_clk, dim_clk, step_tick, dim_tick};
    vecs++;
    if (outs !== 9'b0) begin
      errs++; $display("FAIL reset_outs got=%b want=%b", outs, 9'b0);
    end
    rst = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      sc_e = ((k / 8) % 2) == 1;
      st_e = (k % 8) == 0;
      dc_e = ((k / 3) % 2) == 1;
      dt_e = (k % 3) == 0;
      vecs++;
      if ({step_clk, step_tick, dim_clk, dim_tick} !== {sc_e, st_e, dc_e, dt_e}) begin
        errs++;
        $display("FAIL div_cadence edge=%0d got sclk/stick/dclk/dtick=%b%b%b%b want=%b%b%b%b",
                 k, step_clk, step_tick, dim_clk, dim_tick, sc_e, st_e, dc_e, dt_e);
      end
      vecs++;
      if ({left, right, brake, hazard, runlight} !== 5'b0) begin
        errs++; $display("FAIL idle_levels edge=%0d got=%b want=00000", k,
                         {left, right, brake, hazard, runlight});
      end
    end
  endtask

  task automatic test_debounce();
    sw_left = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      vecs++;
      if (left !== (k >= 6)) begin
        errs++; $display("FAIL left_rise edge=%0d got=%b want=%b", k, left, k >= 6);
      end
    end
    sw_left = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      vecs++;
      if (left !== (k < 6)) begin
        errs++; $display("FAIL left_fall edge=%0d got=%b want=%b", k, left, k < 6);
      end
    end
  endtask

  task automatic test_glitch();
    logic [6:0] pat;
    pat = 7'b1111011;  // applied LSB first: 1,1,0,1,1,1,1
    sw_brake = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 4) sw_brake = 1'b0;
      step();
      vecs++;
      if (brake !== 1'b0) begin
        errs++; $display("FAIL short_pulse edge=%0d got=%b want=0", k, brake);
      end
    end
    for (int k = 1; k <= 9; k++) begin
      if (k <= 7) sw_brake = pat[k-1];
      step();
      vecs++;
      if (brake !== (k >= 9)) begin
        errs++; $display("FAIL bounce edge=%0d got=%b want=%b", k, brake, k >= 9);
      end
    end
    sw_brake = 1'b0;
    repeat (6) step();
    vecs++;
    if (brake !== 1'b0) begin
      errs++; $display("FAIL brake_release got=%b want=0", brake);
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    sw_hazard = 1'b1;
    repeat (6) step();
    vecs++;
    if (hazard !== 1'b1) begin
      errs++; $display("FAIL hazard_on got=%b want=1", hazard);
    end
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (step_clk === 1'b1) found = 1;
    end
    vecs++;
    if (!found) begin
      errs++; $display("FAIL wait_step_clk timeout got=0 want=1 within 20 edges");
    end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({step_clk, hazard, dim_clk} !== 3'b000) begin
      errs++; $display("FAIL async_reset got sclk/haz/dclk=%b want=000",
                       {step_clk, hazard, dim_clk});
    end
    sw_hazard = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      vecs++;
      if ({step_clk, step_tick} !== {2{k == 8}}) begin
        errs++; $display("FAIL post_reset_step edge=%0d got clk/tick=%b%b want=%b%b",
                         k, step_clk, step_tick, k == 8, k == 8);
      end
    end
  endtask

  task automatic test_resync();
    int base1, base2;
    bit t_e, c_e;
`ifdef TAILLIGHT_STEP_RESYNC_EN
    base1 = 14; base2 = 8;
`else
    base1 = 0;  base2 = 0;
`endif
    // right becomes visible after edge 13, while the step counter holds 5
    do_reset();
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 7) sw_right = 1'b1;
      if (k == 12 || k == 13) begin
        vecs++;
        if (right !== (k == 13)) begin
          errs++; $display("FAIL right_rise edge=%0d got=%b want=%b", k, right, k == 13);
        end
      end
      if (k >= 14) begin
        t_e = (k != base1) && ((k - base1) % 8 == 0);
        c_e = ((k - base1) / 8) % 2 == 1;
        vecs++;
        if ({step_clk, step_tick} !== {c_e, t_e}) begin
          errs++; $display("FAIL resync_mid edge=%0d got clk/tick=%b%b want=%b%b",
                           k, step_clk, step_tick, c_e, t_e);
        end
      end
    end
    sw_right = 1'b0;
    // right becomes visible after edge 7, coinciding with the counter at 7
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) sw_right = 1'b1;
      if (k >= 7) begin
        t_e = (k >= 8) && (k != base2) && ((k - base2) % 8 == 0);
        c_e = (k >= 8) && (((k - base2) / 8) % 2 == 1);
        vecs++;
        if ({step_clk, step_tick, right} !== {c_e, t_e, 1'b1}) begin
          errs++; $display("FAIL resync_wrap edge=%0d got clk/tick/right=%b%b%b want=%b%b1",
                           k, step_clk, step_tick, right, c_e, t_e);
        end
      end
    end
    sw_right = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_mid_reset();
    test_resync();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
